irrigation_sequencer: RTL and testbench
=======================================

Name: irrigation_sequencer

Overview:
- Sequences the sprinkler (aspersion) and drip valves from the 2-bit irrigation type code produced by the irrigation-state logic.
- Code meanings: 00 = no irrigation, 01 = aspersion, 10 = drip, 11 = timed aspersion followed by drip.
- Counts the aspersion phase in seconds from a 1 Hz strobe.
- Forces both valves off on a water-level or error fault; a fault latches until explicitly cleared.

Parameters:
- ASP_SECONDS, 22, duration of the aspersion phase in mode 11, in tick_1s pulses (1..2^CNT_W-1).
- CNT_W, 6, width of the seconds counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_1s  in  1  one-clk-wide pulse, once per second.
- irr_type  in  2  irrigation type code (00/01/10/11).
- water_ok  in  1  1 = reservoir level sufficient.
- err  in  1  1 = external error condition.
- fault_clr  in  1  one-clk pulse that releases a latched fault.
- valve_asp  out  1  sprinkler valve drive.
- valve_drip  out  1  drip valve drive.
- fault  out  1  1 while in FAULT.
- state_o  out  3  current state encoding.
- secs_left  out  CNT_W  remaining aspersion seconds; 0 outside ASP_T.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high: on a rising clk edge with reset=1, state goes to IDLE and all outputs go to 0.
- Output timing: all outputs are registered and decoded from the next state, so valves change on the same edge as the state register.
- Latching: irr_type is latched into type_q on the exit from IDLE.
- State encodings: IDLE=000, ASP=001, DRIP=010, ASP_T=011, GAP=100, FAULT=111.
- Fault check (every state except IDLE and FAULT): if err=1 or water_ok=0, go to FAULT next edge. This has priority over every other transition, including a terminal count.
- IDLE: valves off.
  - If irr_type!=00, water_ok=1 and err=0, go to the state for irr_type: 01->ASP, 10->DRIP, 11->ASP_T with secs_left loaded to ASP_SECONDS.
  - If irr_type!=00 but water_ok=0 or err=1, go to FAULT.
- ASP: valve_asp=1. If irr_type!=type_q, go to IDLE; re-entry is evaluated on the following cycle.
- DRIP: valve_drip=1. Same exit rule as ASP, except that type_q=11 exits only when irr_type=00 or irr_type=01.
- ASP_T: valve_asp=1.
  - Each tick_1s decrements secs_left.
  - When secs_left=1 and tick_1s=1: secs_left goes to 0 and the state advances to DRIP, or to GAP if the optional feature is enabled.
  - If irr_type changes before the count expires, go to IDLE and set secs_left to 0.
  - A tick_1s in the same cycle as the entry from IDLE is ignored; counting starts the next cycle.
- FAULT: both valves off, fault=1.
  - Exit to IDLE only when fault_clr=1, err=0 and water_ok=1 in the same cycle.
  - fault_clr is ignored in all other states and in all other conditions.
- Valve invariant: valve_asp and valve_drip are never 1 simultaneously, in any state or cycle.
- Reset mid-operation: reset in any state, including ASP_T mid-count and FAULT, returns to IDLE with valves off next edge. No count is retained.

Optional Feature:
- Macro: IRR_VALVE_GAP_EN.
- When defined, the ASP_T -> DRIP transition passes through GAP:
  - Both valves are off in GAP.
  - The state leaves GAP on the next tick_1s, a 1-second break-before-make.
  - The fault check applies in GAP.
  - An irr_type change in GAP goes to IDLE.
- When undefined, the GAP state and its logic are absent and ASP_T goes directly to DRIP.

Test Plan:
- Reset/idle: assert reset 2 cycles with irr_type=11 -> valves 0, state_o=000, fault 0; after release with irr_type=00, remains IDLE.
- Mode 11 timing (ASP_SECONDS=22, water_ok=1):
  - irr_type=11 -> valve_asp=1 for exactly 22 tick_1s pulses, secs_left counting 22..0.
  - Without the macro, valve_drip=1 on the edge of the 22nd tick.
  - With IRR_VALVE_GAP_EN, both valves are 0 until the 23rd tick, then valve_drip=1.
- Mode change: in ASP with irr_type=01, switch to 10 -> next cycle IDLE with valves 0, following cycle DRIP with valve_drip=1.
- Fault priority: in ASP_T with secs_left=1, drop water_ok in the same cycle as tick_1s -> FAULT, valves 0, fault=1.
  - fault_clr while water_ok=0 -> stays FAULT.
  - With water_ok=1 and err=0, fault_clr -> IDLE.
- Abort mid-count: in ASP_T at secs_left=10, set irr_type=00 -> IDLE, secs_left=0, valves 0. Re-selecting 11 reloads 22.
- Reset mid-operation: reset during DRIP -> next edge IDLE, valve_drip=0. Valve exclusivity is checked every cycle by assertion.

Source files
------------

// File: rtl/irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_sequencer
//
// Purpose:
//   Drives the sprinkler (aspersion) and drip valves from the 2-bit irrigation
//   type code produced by the irrigation-state logic:
//     00 = no irrigation, 01 = aspersion, 10 = drip,
//     11 = timed aspersion (ASP_SECONDS ticks of tick_1s) followed by drip.
//   A low reservoir level or an external error forces both valves off and
//   latches a fault until fault_clr is pulsed with the fault condition gone.
//
// Optional feature:
//   `define IRR_VALVE_GAP_EN inserts a GAP state between the timed aspersion
//   and the drip phase: both valves stay off until the next tick_1s, giving a
//   one-second break-before-make between the two valves.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   tick_1s    in   one-clk-wide pulse, once per second
//   irr_type   in   [1:0] irrigation type code
//   water_ok   in   1 = reservoir level sufficient
//   err        in   1 = external error condition
//   fault_clr  in   one-clk pulse releasing a latched fault
//   valve_asp  out  sprinkler valve drive
//   valve_drip out  drip valve drive
//   fault      out  1 while in FAULT
//   state_o    out  [2:0] current state encoding
//   secs_left  out  [CNT_W-1:0] remaining aspersion seconds, 0 outside ASP_T
// -----------------------------------------------------------------------------
module irrigation_sequencer #(
    parameter int ASP_SECONDS = 22,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1s,
    input  logic [1:0]       irr_type,
    input  logic             water_ok,
    input  logic             err,
    input  logic             fault_clr,
    output logic             valve_asp,
    output logic             valve_drip,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] secs_left
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ASP   = 3'b001,
        DRIP  = 3'b010,
        ASP_T = 3'b011,
`ifdef IRR_VALVE_GAP_EN
        GAP   = 3'b100,
`endif
        FAULT = 3'b111
    } state_t;

    localparam logic [CNT_W-1:0] ASP_LOAD = CNT_W'(ASP_SECONDS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [CNT_W-1:0] secs_q, secs_d;
    logic             valve_asp_q, valve_asp_d;
    logic             valve_drip_q, valve_drip_d;
    logic             fault_q, fault_d;

    logic             fault_cond;
    logic             type_chg;

    // Next-state, latched type and seconds counter. The counter is only
    // carried while the next state is ASP_T; every other path clears it.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        secs_d     = '0;
        fault_cond = err || !water_ok;
        type_chg   = (irr_type != type_q);

        case (state_q)
            IDLE: begin
                if (irr_type != 2'b00) begin
                    type_d = irr_type;
                    if (fault_cond) begin
                        state_d = FAULT;
                    end else begin
                        case (irr_type)
                            2'b01:   state_d = ASP;
                            2'b10:   state_d = DRIP;
                            default: begin
                                state_d = ASP_T;
                                secs_d  = ASP_LOAD;
                            end
                        endcase
                    end
                end
            end

            ASP: begin
                if (fault_cond) begin
                    state_d = FAULT;
                end else if (type_chg) begin
                    state_d = IDLE;
                end
            end

            DRIP: begin
                // In the drip tail of mode 11, a request for plain drip (10)
                // is compatible and keeps the valve open.
                if (fault_cond) begin
                    state_d = FAULT;
                end else if (type_q == 2'b11) begin
                    if (irr_type == 2'b00 || irr_type == 2'b01) begin
                        state_d = IDLE;
                    end
                end else if (type_chg) begin
                    state_d = IDLE;
                end
            end

            ASP_T: begin
                // Fault outranks the terminal count and the abort.
                if (fault_cond) begin
                    state_d = FAULT;
                end else if (type_chg) begin
                    state_d = IDLE;
                end else if (tick_1s) begin
                    if (secs_q <= ONE) begin
`ifdef IRR_VALVE_GAP_EN
                        state_d = GAP;
`else
                        state_d = DRIP;
`endif
                    end else begin
                        secs_d = secs_q - ONE;
                    end
                end else begin
                    secs_d = secs_q;
                end
            end

`ifdef IRR_VALVE_GAP_EN
            GAP: begin
                if (fault_cond) begin
                    state_d = FAULT;
                end else if (type_chg) begin
                    state_d = IDLE;
                end else if (tick_1s) begin
                    state_d = DRIP;
                end
            end
`endif

            FAULT: begin
                if (fault_clr && !fault_cond) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs decoded from the next state so they switch together with it.
        valve_asp_d  = (state_d == ASP) || (state_d == ASP_T);
        valve_drip_d = (state_d == DRIP);
        fault_d      = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            type_q       <= 2'b00;
            secs_q       <= '0;
            valve_asp_q  <= 1'b0;
            valve_drip_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            secs_q       <= secs_d;
            valve_asp_q  <= valve_asp_d;
            valve_drip_q <= valve_drip_d;
            fault_q      <= fault_d;
        end
    end

    assign valve_asp  = valve_asp_q;
    assign valve_drip = valve_drip_q;
    assign fault      = fault_q;
    assign state_o    = state_q;
    assign secs_left  = secs_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irrigation_sequencer
//
// Directed stimulus for irrigation_sequencer. Each stimulus cycle that needs
// checking pushes the hand-computed expected outputs into a queue; a monitor
// on the falling edge pops one entry per cycle and compares it with the DUT.
// The monitor also checks valve exclusivity on every cycle.
// -----------------------------------------------------------------------------
module tb_irrigation_sequencer;

    localparam int ASP_SECONDS = 22;
    localparam int CNT_W       = 6;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_ASP   = 3'b001;
    localparam logic [2:0] S_DRIP  = 3'b010;
    localparam logic [2:0] S_ASPT  = 3'b011;
    localparam logic [2:0] S_GAP   = 3'b100;
    localparam logic [2:0] S_FAULT = 3'b111;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick_1s;
    logic [1:0]       irr_type;
    logic             water_ok;
    logic             err;
    logic             fault_clr;
    logic             valve_asp;
    logic             valve_drip;
    logic             fault;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] secs_left;

    irrigation_sequencer #(
        .ASP_SECONDS (ASP_SECONDS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1s    (tick_1s),
        .irr_type   (irr_type),
        .water_ok   (water_ok),
        .err        (err),
        .fault_clr  (fault_clr),
        .valve_asp  (valve_asp),
        .valve_drip (valve_drip),
        .fault      (fault),
        .state_o    (state_o),
        .secs_left  (secs_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             asp;
        logic             drip;
        logic             flt;
        logic [CNT_W-1:0] secs;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    excl_en  = 1'b0;

    // One clock edge; inputs may change right after it returns.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [2:0] st,
                              input logic asp, input logic drip,
                              input logic flt, input int secs);
        exp_t e;
        e.st   = st;
        e.asp  = asp;
        e.drip = drip;
        e.flt  = flt;
        e.secs = CNT_W'(secs);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are registered, so the falling edge is a stable point.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (excl_en) begin
            checks++;
            if (valve_asp === 1'b1 && valve_drip === 1'b1) begin
                failures++;
                $display("FAIL valve_excl t=%0t: asp=%b drip=%b, required not both 1",
                         $time, valve_asp, valve_drip);
            end
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (state_o !== e.st || valve_asp !== e.asp || valve_drip !== e.drip ||
                fault !== e.flt || secs_left !== e.secs) begin
                failures++;
                $display("FAIL %s t=%0t: got st=%b asp=%b drip=%b fault=%b secs=%0d, required st=%b asp=%b drip=%b fault=%b secs=%0d",
                         nm, $time, state_o, valve_asp, valve_drip, fault, secs_left,
                         e.st, e.asp, e.drip, e.flt, e.secs);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        tick_1s   = 1'b0;
        irr_type  = 2'b11;
        water_ok  = 1'b1;
        err       = 1'b0;
        fault_clr = 1'b0;

        // Reset for two cycles with a request pending.
        clk1();
        clk1();
        expect_out("reset_idle", S_IDLE, 0, 0, 0, 0);
        excl_en  = 1'b1;
        reset    = 1'b0;
        irr_type = 2'b00;
        clk1(); expect_out("idle_hold0", S_IDLE, 0, 0, 0, 0);
        clk1(); expect_out("idle_hold1", S_IDLE, 0, 0, 0, 0);

        // Mode 11: entry with a coincident tick that must be ignored.
        irr_type = 2'b11;
        tick_1s  = 1'b1;
        clk1(); expect_out("aspt_entry", S_ASPT, 1, 0, 0, 22);
        tick_1s = 1'b0;
        clk1(); expect_out("aspt_hold", S_ASPT, 1, 0, 0, 22);
        for (int i = 1; i <= ASP_SECONDS; i++) begin
            tick_1s = 1'b1;
            clk1();
            tick_1s = 1'b0;
            if (i < ASP_SECONDS) begin
                expect_out("aspt_count", S_ASPT, 1, 0, 0, ASP_SECONDS - i);
                clk1();
                expect_out("aspt_between", S_ASPT, 1, 0, 0, ASP_SECONDS - i);
            end else begin
`ifdef IRR_VALVE_GAP_EN
                expect_out("gap_entry", S_GAP, 0, 0, 0, 0);
                clk1(); expect_out("gap_hold", S_GAP, 0, 0, 0, 0);
                tick_1s = 1'b1;
                clk1(); expect_out("gap_to_drip", S_DRIP, 0, 1, 0, 0);
                tick_1s = 1'b0;
`else
                expect_out("aspt_to_drip", S_DRIP, 0, 1, 0, 0);
`endif
            end
        end

        // Drip tail of mode 11: 10 is compatible, 01 exits.
        irr_type = 2'b10;
        clk1(); expect_out("drip11_keep10", S_DRIP, 0, 1, 0, 0);
        irr_type = 2'b01;
        clk1(); expect_out("drip11_exit01", S_IDLE, 0, 0, 0, 0);
        clk1(); expect_out("asp_reentry", S_ASP, 1, 0, 0, 0);

        // Mode change ASP -> IDLE -> DRIP.
        irr_type = 2'b10;
        clk1(); expect_out("asp_chg_idle", S_IDLE, 0, 0, 0, 0);
        clk1(); expect_out("drip_entry", S_DRIP, 0, 1, 0, 0);
        fault_clr = 1'b1;
        clk1(); expect_out("drip_clr_ign", S_DRIP, 0, 1, 0, 0);
        fault_clr = 1'b0;

        // Reset mid-drip.
        reset = 1'b1;
        clk1(); expect_out("reset_in_drip", S_IDLE, 0, 0, 0, 0);
        reset    = 1'b0;
        irr_type = 2'b00;
        clk1(); expect_out("post_reset_idle", S_IDLE, 0, 0, 0, 0);

        // Fault priority over the terminal count.
        irr_type = 2'b11;
        clk1(); expect_out("aspt_entry2", S_ASPT, 1, 0, 0, 22);
        for (int i = 1; i < ASP_SECONDS; i++) begin
            tick_1s = 1'b1;
            clk1();
            tick_1s = 1'b0;
        end
        expect_out("aspt_at_one", S_ASPT, 1, 0, 0, 1);
        tick_1s  = 1'b1;
        water_ok = 1'b0;
        clk1(); expect_out("fault_prio", S_FAULT, 0, 0, 1, 0);
        tick_1s   = 1'b0;
        fault_clr = 1'b1;
        clk1(); expect_out("clr_water_low", S_FAULT, 0, 0, 1, 0);
        fault_clr = 1'b0;
        water_ok  = 1'b1;
        clk1(); expect_out("fault_latched", S_FAULT, 0, 0, 1, 0);
        fault_clr = 1'b1;
        err       = 1'b1;
        clk1(); expect_out("clr_with_err", S_FAULT, 0, 0, 1, 0);
        err      = 1'b0;
        irr_type = 2'b00;
        clk1(); expect_out("fault_release", S_IDLE, 0, 0, 0, 0);
        fault_clr = 1'b0;

        // Abort mid-count at secs_left=10, then reload.
        irr_type = 2'b11;
        clk1(); expect_out("aspt_entry3", S_ASPT, 1, 0, 0, 22);
        for (int i = 1; i <= 12; i++) begin
            tick_1s = 1'b1;
            clk1();
            tick_1s = 1'b0;
        end
        expect_out("aspt_at_ten", S_ASPT, 1, 0, 0, 10);
        irr_type = 2'b00;
        clk1(); expect_out("abort_idle", S_IDLE, 0, 0, 0, 0);
        irr_type = 2'b11;
        clk1(); expect_out("reload_22", S_ASPT, 1, 0, 0, 22);

        // External error during ASP_T.
        err = 1'b1;
        clk1(); expect_out("err_in_aspt", S_FAULT, 0, 0, 1, 0);
        err       = 1'b0;
        fault_clr = 1'b1;
        irr_type  = 2'b00;
        clk1(); expect_out("release2", S_IDLE, 0, 0, 0, 0);
        fault_clr = 1'b0;

        // Request from IDLE with low water goes straight to FAULT.
        irr_type = 2'b10;
        water_ok = 1'b0;
        clk1(); expect_out("idle_to_fault", S_FAULT, 0, 0, 1, 0);
        water_ok = 1'b1;
        clk1(); expect_out("fault_no_clr", S_FAULT, 0, 0, 1, 0);
        reset = 1'b1;
        clk1(); expect_out("reset_in_fault", S_IDLE, 0, 0, 0, 0);
        reset    = 1'b0;
        irr_type = 2'b00;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
